// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with glitch rejection, framing-error strobe and break hold-off
// clk, rst        : system clock, synchronous active-high reset
// ser_in          : asynchronous serial line, idle high
// byte_out        : last correctly received byte
// byte_valid      : one-cycle strobe, byte_out updated this cycle
// frame_err       : one-cycle strobe, stop bit sampled low
// busy            : receiver is inside a frame or waiting out a break
module serial_rx #(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int TW   = $clog2(DIV);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BRK   = 3'd4;
   logic          s1, s2;
   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [2:0]    idx;
   logic [7:0]    sh;
   logic          bit_end;
   assign bit_end = timer == TW'(DIV - 1);
   assign busy    = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b1;
         s2         <= 1'b1;
         state      <= IDLE;
         timer      <= '0;
         idx        <= '0;
         sh         <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         s1         <= ser_in;
         s2         <= s1;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         timer      <= timer + 1'b1;
         case (state)
            IDLE: begin
               timer <= '0;
               if (!s2) state <= START;
            end
            START: if (timer == TW'(HALF - 1)) begin
               timer <= '0;
               idx   <= '0;
               state <= s2 ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
               timer <= '0;
               sh    <= {s2, sh[7:1]};
               idx   <= idx + 3'd1;
               if (idx == 3'd7) state <= STOP;
            end
            STOP: if (bit_end) begin
               timer <= '0;
               if (s2) begin
                  byte_out   <= sh;
                  byte_valid <= 1'b1;
                  state      <= IDLE;
               end else begin
                  frame_err <= 1'b1;
                  state     <= BRK;
               end
            end
            // a held-low line must go high before a new start bit is accepted
            BRK: begin
               timer <= '0;
               if (s2) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames against a cycle-level event model of the receiver
module tb_serial_rx;
   typedef struct {
      int         inst;
      int         cyc;
      bit         err;
      logic [7:0] b;
   } ev_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] ser = 2'b11;
   logic [7:0] bo [2];
   logic       bv [2];
   logic       fe [2];
   logic       bz [2];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;
   ev_t        q [$];
   logic [7:0] mbyte [2] = '{8'h00, 8'h00};
   int         win_lo [2] = '{1, 1};
   int         win_hi [2] = '{0, 0};
   int         last_v [2] = '{0, 0};
   int         nv [2] = '{0, 0};
   int         ne [2] = '{0, 0};

   serial_rx u_main (.clk(clk), .rst(rst), .ser_in(ser[0]), .byte_out(bo[0]),
                     .byte_valid(bv[0]), .frame_err(fe[0]), .busy(bz[0]));
   serial_rx #(.CLK_FREQ(25000000), .BAUD(1562500)) u_fast (.clk(clk), .rst(rst), .ser_in(ser[1]),
                     .byte_out(bo[1]), .byte_valid(bv[1]), .frame_err(fe[1]), .busy(bz[1]));

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Model: each frame yields exactly one strobe at start edge + 2 + HALF + 9*DIV,
   // and busy spans from start edge + 2 up to the cycle before that strobe.
   always @(negedge clk) if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
         bit ev, ev_v, ev_e;
         ev   = q.size() > 0 && q[0].inst == i && q[0].cyc == cyc;
         ev_v = ev && !q[0].err;
         ev_e = ev && q[0].err;
         if (ev_v) mbyte[i] = q[0].b;
         chk($sformatf("byte_valid%0d", i), 32'(bv[i]), 32'(ev_v));
         chk($sformatf("frame_err%0d", i), 32'(fe[i]), 32'(ev_e));
         chk($sformatf("byte_out%0d", i), 32'(bo[i]), 32'(mbyte[i]));
         chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(cyc >= win_lo[i] && cyc <= win_hi[i]));
         if (bv[i] === 1'b1) begin
            last_v[i] = cyc;
            nv[i]++;
         end
         if (fe[i] === 1'b1) ne[i]++;
         if (ev) void'(q.pop_front());
      end
   end

   // Plays the transmitter: start bit, 8 data bits LSB first, stop bit, DIV clocks each.
   task automatic send(input int i, input logic [7:0] b, input logic stop, input int abort, output int e0);
      int d = i ? 16 : 217;
      int h = d / 2;
      logic [9:0] fr = {stop, b, 1'b0};
      e0 = cyc + 1;
      win_lo[i] = e0 + 2;
      win_hi[i] = stop ? e0 + 1 + h + 9 * d : 32'h7fffffff;
      q.push_back('{i, e0 + 2 + h + 9 * d, !stop, b});
      for (int k = 0; k < 10; k++) begin
         ser[i] = fr[k];
         for (int c = 0; c < d; c++) begin
            if (k == abort && c == h) begin
               rst = 1'b1;
               step();
               rst = 1'b0;
               q.delete();
               mbyte[i] = 8'h00;
               win_hi[i] = 0;
            end else step();
         end
      end
   endtask

   initial begin
      int e0, t0, t1, t2;
      repeat (3) step();
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (1000) step();
      chk("idle_byte", 32'(bo[0]), 32'h00);
      chk("idle_busy", 32'(bz[0]), 32'h0);
      chk("idle_strobes", 32'(nv[0] + ne[0]), 32'd0);
      send(0, 8'hA5, 1'b1, -1, e0);
      chk("a5_latency", 32'(last_v[0] - e0), 32'd2063);
      chk("a5_byte", 32'(bo[0]), 32'hA5);
      repeat (200) step();
      send(0, 8'h00, 1'b1, -1, e0);
      t0 = last_v[0];
      send(0, 8'hFF, 1'b1, -1, e0);
      t1 = last_v[0];
      chk("b2b_ff", 32'(bo[0]), 32'hFF);
      send(0, 8'h55, 1'b1, -1, e0);
      t2 = last_v[0];
      chk("b2b_gap1", 32'(t1 - t0), 32'd2170);
      chk("b2b_gap2", 32'(t2 - t1), 32'd2170);
      chk("b2b_55", 32'(bo[0]), 32'h55);
      repeat (200) step();
      e0 = cyc + 1;
      win_lo[0] = e0 + 2;
      win_hi[0] = e0 + 1 + 108;
      ser[0] = 1'b0;
      repeat (50) step();
      ser[0] = 1'b1;
      repeat (300) step();
      chk("glitch_nostrobe", 32'(nv[0]), 32'd4);
      send(0, 8'h3C, 1'b1, -1, e0);
      chk("after_glitch", 32'(bo[0]), 32'h3C);
      repeat (200) step();
      send(0, 8'h81, 1'b0, -1, e0);
      repeat (5000) step();
      chk("break_busy", 32'(bz[0]), 32'h1);
      chk("break_err_once", 32'(ne[0]), 32'd1);
      chk("break_keep", 32'(bo[0]), 32'h3C);
      ser[0] = 1'b1;
      win_hi[0] = cyc + 2;
      repeat (200) step();
      chk("break_exit", 32'(bz[0]), 32'h0);
      send(0, 8'h42, 1'b1, -1, e0);
      chk("after_break", 32'(bo[0]), 32'h42);
      repeat (200) step();
      send(0, 8'hF0, 1'b1, 5, e0);
      chk("abort_byte", 32'(bo[0]), 32'h00);
      repeat (500) step();
      send(0, 8'h7E, 1'b1, -1, e0);
      chk("after_abort", 32'(bo[0]), 32'h7E);
      chk("main_err_total", 32'(ne[0]), 32'd1);
      repeat (50) step();
      for (int b = 0; b < 256; b++) send(1, 8'(b), 1'b1, -1, e0);
      repeat (20) step();
      chk("loop_count", 32'(nv[1]), 32'd256);
      chk("loop_errs", 32'(ne[1]), 32'd0);
      chk("loop_last", 32'(bo[1]), 32'hFF);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_rx.md
# serial_rx

UART receiver, the receive-side counterpart of the board's serial_tx byte transmitter. It samples the asynchronous `rs232_rx` line in the 25 MHz domain, recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit), and presents each received byte with a one-cycle valid strobe. Framing errors are flagged. Glitches shorter than half a bit are rejected as false starts.

## Interface
- `CLK_FREQ`, 25000000, clock frequency in Hz
- `BAUD`, 115200, line bit rate
- derived: `DIV = CLK_FREQ / BAUD` (integer division, 217 at defaults); `HALF = DIV / 2` (108)

- `clk`  in  1  system clock, driven from `clk_25m` at top level
- `rst`  in  1  reset; one clock, synchronous, active-high
- `ser_in`  in  1  asynchronous serial line, idle high
- `byte_out`  out  8  last correctly received byte
- `byte_valid`  out  1  one-cycle strobe: `byte_out` updated this cycle
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- Synchronizer: two flops `s1`→`s2`; reset value 1. All decisions use `s2` only.
- Counters: bit-timer 0..DIV-1; bit index 0..7; 8-bit shift register.
- FSM states:
  - IDLE: entered when `s2`==0 → START, timer cleared.
  - START: at timer==HALF-1 sample `s2`; 0 → DATA, timer cleared, index 0; 1 → IDLE (glitch, no strobe).
  - DATA: every DIV cycles sample `s2` into shift register, LSB first (right shift, new bit in MSB). After index 7 → STOP.
  - STOP: after DIV cycles sample `s2`.
    - 1 → load `byte_out`, pulse `byte_valid`, → IDLE.
    - 0 → pulse `frame_err`, `byte_out` unchanged, → BREAK.
  - BREAK: wait for `s2`==1 → IDLE. This prevents a held-low line or break from re-triggering.
- Return to IDLE occurs at mid-stop-bit, so back-to-back frames with no idle gap are received.
- `byte_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset values: `byte_out`=0x00, `byte_valid`=0, `frame_err`=0, `busy`=0, state IDLE.
- Reset mid-frame aborts the frame: no strobe, `byte_out`=0x00, resume in IDLE.

## Timing
- Edge 0 is the first rising edge at which `ser_in` is sampled low (start bit).
- `s2` is low after edge 1. START is entered at edge 2.
- Start check is at edge 2+HALF.
- Data bit k (k=0..7) is sampled at edge 2+HALF+(k+1)·DIV.
- Stop bit is sampled at edge 2+HALF+9·DIV (2063 at defaults). The strobe is high in the cycle following that edge.
- `busy` rises after edge 2 and falls with the strobe edge, or on glitch rejection. After a framing error it falls when BREAK exits.
- The sampling point is at 50% of each bit (±1 clk). This tolerates about ±4% total baud mismatch.
- `ser_in` changes adjacent to clock edges are legal. The synchronizer absorbs metastability.

## Test plan
- Reset, line idle high for 1000 cycles → all outputs 0, `busy`=0, no strobe.
- Send 0xA5 at 115200 (DIV=217 clk per bit) → `byte_valid` one cycle after edge 2063, `byte_out`=0xA5, `frame_err`=0.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three `byte_valid` strobes spaced 10·DIV=2170 cycles apart, values in order.
- Low glitch of 50 cycles on idle line → returns to IDLE, no strobe. A following 0x3C frame is received correctly.
- Frame 0x81 with stop bit forced low, then line held low 5000 cycles → single `frame_err` pulse, `byte_out` keeps its previous value, `busy` stays high until line returns high, then a 0x42 frame is received correctly.
- Assert `rst` for one cycle during data bit 4 of a frame → no strobe, `byte_out`=0x00. The next full frame 0x7E is received correctly.
- Loopback: serial_tx (same clock) drives `ser_in` with 256 bytes 0x00..0xFF → all received bytes match, zero `frame_err`.
